// File: rtl/counter_seq.sv
// counter_seq
//
// Command-driven sequencer for an external 8-bit loadable counter. A
// start/end command is taken over a valid/ready handshake. The sequencer
// loads the counter with the start value, then enables it until the count
// reaches the end value, and pulses done when it gets there. It also keeps
// its own expected count and raises a sticky error if the counter ever
// disagrees with it. This block is the only driver of the counter's load,
// enable and data_in.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  sequencer can accept a command (IDLE)
//   cmd_start  in   value loaded into the counter
//   cmd_end    in   terminal count value
//   hold       in   pause; suppresses ctr_enable while high
//   abort      in   cancels the active command (honoured in RUN only)
//   ctr_load   out  counter load strobe
//   ctr_enable out  counter count enable
//   ctr_data   out  counter data_in (always the captured start value)
//   ctr_count  in   counter count output
//   busy       out  high in LOAD, RUN and DONE
//   done       out  one-cycle completion pulse
//   err        out  sticky count-mismatch flag, cleared only by rst

module counter_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             hold,
    input  logic             abort,
    output logic             ctr_load,
    output logic             ctr_enable,
    output logic [WIDTH-1:0] ctr_data,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q,   end_d;
    logic [WIDTH-1:0] exp_q,   exp_d;
    logic             err_q,   err_d;

    logic             at_end;

    assign at_end = (ctr_count == end_q);

    // The counter's data_in is only sampled while ctr_load is high, so it can
    // simply follow the captured start value; this also makes it 0 after reset.
    assign ctr_data = start_q;
    assign err      = err_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        exp_d      = exp_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ctr_load   = 1'b0;
        ctr_enable = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    start_d = cmd_start;
                    end_d   = cmd_end;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                busy     = 1'b1;
                ctr_load = 1'b1;
                // The counter shows start_q from the next cycle on, so the
                // checker's expectation starts there too.
                exp_d    = start_q;
                state_d  = S_RUN;
            end

            S_RUN: begin
                busy       = 1'b1;
                ctr_enable = !hold && !abort && !at_end;
                if (ctr_enable) begin
                    exp_d = exp_q + 1'b1;
                end
                if (ctr_count != exp_q) begin
                    err_d = 1'b1;
                end
                // abort takes priority over reaching the end value: a
                // cancelled command never produces a done pulse.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                if (ctr_count != exp_q) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, and every register here
        // has a defined reset value (including the captured command), so the
        // outputs that decode from them are known the cycle after rst.
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= '0;
            end_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Testbench for counter_seq. A behavioural loadable counter (async active-low
// reset, load over enable) sits beside the sequencer. Each accepted command
// gets an expected completion record pushed into a scoreboard queue; a
// monitor process pops and compares whenever the DUT pulses done.

module tb_counter_seq;

    typedef struct {
        int         done_cyc;
        int         load_cyc;
        int         n;
        logic [7:0] start;
        logic [7:0] fin;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_start = 8'h00;
    logic [7:0] cmd_end = 8'h00;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic       force_bad = 1'b0;

    logic       cmd_ready;
    logic       ctr_load;
    logic       ctr_enable;
    logic [7:0] ctr_data;
    logic [7:0] ctr_count;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] cnt_q;
    logic       rst_n;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    exp_t       sb[$];
    logic       err_model = 1'b0;

    // monitor state
    int         mon_load_cyc = -1;
    int         mon_en_cnt = 0;
    bit         mon_ready_next = 1'b0;
    exp_t       mon_e;

    // main-process scratch
    logic [7:0] rs;
    logic [7:0] re;
    int         rn;
    logic [63:0] rhm;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Team counter model.
    assign rst_n = ~rst;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (ctr_load) begin
            cnt_q <= ctr_data;
        end else if (ctr_enable) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    assign ctr_count = force_bad ? 8'h99 : cnt_q;

    counter_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .hold      (hold),
        .abort     (abort),
        .ctr_load  (ctr_load),
        .ctr_enable(ctr_enable),
        .ctr_data  (ctr_data),
        .ctr_count (ctr_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},  cmd_ready,  1'b1);
        check({tag, "_busy"},       busy,       1'b0);
        check({tag, "_done"},       done,       1'b0);
        check({tag, "_err"},        err,        1'b0);
        check({tag, "_ctr_load"},   ctr_load,   1'b0);
        check({tag, "_ctr_enable"}, ctr_enable, 1'b0);
        check({tag, "_ctr_data"},   ctr_data,   8'h00);
    endtask

    // Monitor: pops one scoreboard record per done pulse.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_ready_next = 1'b0;
                mon_en_cnt     = 0;
            end else begin
                if (mon_ready_next) begin
                    check("ready_after_done", cmd_ready, 1'b1);
                    check("idle_after_done",  busy,      1'b0);
                    mon_ready_next = 1'b0;
                end
                if (ctr_load) begin
                    if (sb.size() > 0) check("load_data", ctr_data, sb[0].start);
                    mon_load_cyc = cyc;
                    mon_en_cnt   = 0;
                end
                if (ctr_enable) mon_en_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", done, 1'b0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("done_cycle",    cyc,          mon_e.done_cyc);
                        check("load_cycle",    mon_load_cyc, mon_e.load_cyc);
                        check("enable_cycles", mon_en_cnt,   mon_e.n);
                        check("final_count",   ctr_count,    mon_e.fin);
                        check("err_at_done",   err,          mon_e.err);
                        mon_ready_next = 1'b1;
                    end
                end
            end
        end
    end

    // Issue one command and drive hold/abort/fault/reset by cycle offset from
    // the accept cycle (offset 0). Offsets < 0 disable that event.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] e, input logic [63:0] hm,
                           input int abort_off, input int bad_off, input int rst_off);
        logic [7:0] d;
        logic [7:0] expc [64];
        int n, t, k, stop, end_off, span, acc;
        exp_t r;

        // Reference: the count advances by one on every non-hold RUN cycle
        // until it has moved N = (end - start) mod 256 steps, then freezes.
        d = e - s;
        n = int'(d);
        t = 2;
        k = 0;
        while (t < 62) begin
            expc[t] = s + 8'(k);
            if (t == abort_off) break;
            if (k == n) break;
            if (!hm[t]) k++;
            t++;
        end
        stop = t;
        for (int i = stop + 1; i < 64; i++) expc[i] = s + 8'(k);
        end_off = (abort_off >= 0) ? abort_off : stop + 1;
        span    = (rst_off >= 0) ? rst_off + 2 : end_off + 2;
        if (bad_off >= 0) err_model = 1'b1;

        @(posedge clk);
        #1;
        cmd_start = s;
        cmd_end   = e;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            check("accept_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end

        if (abort_off < 0 && rst_off < 0) begin
            r.done_cyc = acc + stop + 1;
            r.load_cyc = acc + 1;
            r.n        = n;
            r.start    = s;
            r.fin      = e;
            r.err      = err_model;
            sb.push_back(r);
        end

        for (int off = 1; off <= span; off++) begin
            @(posedge clk);
            #1;
            // cmd_valid is held for only the accept cycle; a fresh command
            // shows up during busy to confirm it is not taken.
            cmd_valid = (off == 3);
            cmd_start = 8'hA5;
            cmd_end   = 8'h5A;
            hold      = hm[off];
            abort     = (off == abort_off);
            force_bad = (off == bad_off);
            rst       = (off == rst_off);
            @(negedge clk);
            if (rst_off >= 0 && off == rst_off + 1) begin
                check_reset_values("mid_reset");
                check("mid_reset_count", ctr_count, 8'h00);
                err_model = 1'b0;
            end else if (rst_off < 0 || off < rst_off) begin
                if (off >= 2 && off != bad_off) check("count", ctr_count, expc[off]);
                if (off <= end_off) begin
                    check("ready_low_busy", cmd_ready, 1'b0);
                    check("busy_high", busy, 1'b1);
                end else begin
                    check("ready_high_idle", cmd_ready, 1'b1);
                    check("busy_low", busy, 1'b0);
                end
            end
        end
        cmd_valid = 1'b0;
        hold      = 1'b0;
        abort     = 1'b0;
        force_bad = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain run, wrap-around, zero distance, hold in RUN.
        run_cmd(8'h10, 8'h15, 64'h0, -1, -1, -1);
        run_cmd(8'hFC, 8'h02, 64'h0, -1, -1, -1);
        run_cmd(8'h42, 8'h42, 64'h0, -1, -1, -1);
        run_cmd(8'h00, 8'h0A, 64'h0000_0000_0000_00E0, -1, -1, -1);

        // Abort when count shows 0x05, then a normal command.
        run_cmd(8'h00, 8'h20, 64'h0, 7, -1, -1);
        run_cmd(8'h30, 8'h31, 64'h0, -1, -1, -1);

        // Injected mismatch; err must survive into the next command.
        run_cmd(8'h40, 8'h48, 64'h0, -1, 4, -1);
        run_cmd(8'h50, 8'h52, 64'h0, -1, -1, -1);
        check("err_sticky", err, 1'b1);

        // Reset mid-RUN clears everything including err.
        run_cmd(8'h60, 8'h70, 64'h0, -1, -1, 6);

        // Randomized commands with random hold patterns.
        for (int i = 0; i < 20; i++) begin
            rs  = 8'($urandom);
            rn  = $urandom_range(0, 12);
            re  = rs + 8'(rn);
            rhm = {32'h0, $urandom & $urandom};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_cmd(rs, re, rhm, -1, -1, -1);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("err_final", err, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
